// File: rtl/cacheline_word_adapter.sv
// cacheline_word_adapter: splits whole-line read/write requests into
// LINE_WORDS single-word accesses on a 32-bit memory port and returns
// the assembled line with a one-cycle line_resp pulse.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   line_read/line_write  line request, held until line_resp
//   line_address          byte address (low OFFSET_BITS ignored)
//   line_wdata            write line, word i at [32i+31:32i]
//   line_rdata            assembled read line, same packing
//   line_resp             one-cycle completion pulse
//   mem_read/mem_write    one-cycle word strobes
//   mem_wmask             byte mask (4'hF on write)
//   mem_address           word byte address
//   mem_wdata             word write data
//   mem_resp/mem_rdata    memory word response and read data
module cacheline_word_adapter #(
    parameter int LINE_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_read,
    input  logic                    line_write,
    input  logic [31:0]             line_address,
    input  logic [32*LINE_WORDS-1:0] line_wdata,
    output logic [32*LINE_WORDS-1:0] line_rdata,
    output logic                    line_resp,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [3:0]              mem_wmask,
    output logic [31:0]             mem_address,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_resp,
    input  logic [31:0]             mem_rdata
);

    localparam int OFFSET_BITS = $clog2(LINE_WORDS * 4);
    localparam int CW          = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           count;
    logic [31:0]             base;
    logic                    op_write;
    logic [32*LINE_WORDS-1:0] wbuf;
    logic [32*LINE_WORDS-1:0] rbuf;
    logic [31:0]             word_addr;
    logic [31:0]             word_data;
    logic                    req;
    logic                    unused_offset;

    assign req           = line_read | line_write;
    assign unused_offset = ^line_address[OFFSET_BITS-1:0];

    // Base is line aligned, so base + 4*count never carries out of the line.
    assign word_addr = base + {{(30 - CW){1'b0}}, count, 2'b00};
    assign word_data = wbuf[{count, 5'd0} +: 32];

    assign line_rdata = rbuf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            base     <= '0;
            op_write <= 1'b0;
            wbuf     <= '0;
            rbuf     <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        base     <= {line_address[31:OFFSET_BITS],
                                     {OFFSET_BITS{1'b0}}};
                        wbuf     <= line_wdata;
                        op_write <= line_write;
                        count    <= '0;
                    end
                end
                WAIT: begin
                    if (mem_resp) begin
                        if (!op_write) begin
                            rbuf[{count, 5'd0} +: 32] <= mem_rdata;
                        end
                        if (count != LAST) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        line_resp   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = 4'h0;
        mem_address = 32'h0;
        mem_wdata   = 32'h0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_read    = ~op_write;
                mem_write   = op_write;
                mem_address = word_addr;
                mem_wmask   = op_write ? 4'hF : 4'h0;
                mem_wdata   = op_write ? word_data : 32'h0;
                state_next  = WAIT;
            end
            WAIT: begin
                // Strobes drop here: the memory re-samples a held strobe.
                mem_address = word_addr;
                mem_wmask   = op_write ? 4'hF : 4'h0;
                mem_wdata   = op_write ? word_data : 32'h0;
                if (mem_resp) begin
                    state_next = (count == LAST) ? DONE : ISSUE;
                end
            end
            DONE: begin
                line_resp  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_word_adapter.sv
// Directed bench for cacheline_word_adapter with a negedge-driven
// word memory model that can stretch the response of one address.
module tb_cacheline_word_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_wmask;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    cacheline_word_adapter #(.LINE_WORDS(8)) dut (
        .clk(clk),
        .rst(rst),
        .line_read(line_read),
        .line_write(line_write),
        .line_address(line_address),
        .line_wdata(line_wdata),
        .line_rdata(line_rdata),
        .line_resp(line_resp),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_wmask(mem_wmask),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_resp(mem_resp),
        .mem_rdata(mem_rdata)
    );

    // Memory model: strobe seen at one negedge, response one cycle later
    // (plus delay_amt extra cycles when the address matches delay_addr).
    logic [31:0] mem [0:4095];
    logic        pend = 1'b0;
    int          dcnt = 0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] delay_addr = 32'hFFFF_FFFF;
    int          delay_amt = 0;

    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            paddr    = mem_address;
            pend     = 1'b1;
            dcnt     = (mem_address == delay_addr) ? delay_amt : 0;
            mem_resp = 1'b0;
            if (mem_write) mem[mem_address[13:2]] = mem_wdata;
        end else if (pend) begin
            if (dcnt == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = mem[paddr[13:2]];
                pend      = 1'b0;
            end else begin
                dcnt     = dcnt - 1;
                mem_resp = 1'b0;
            end
        end else begin
            mem_resp  = 1'b0;
            mem_rdata = 32'h0;
        end
    end

    logic [31:0] addr_at [0:127];
    logic [31:0] wd_at   [0:127];
    logic [3:0]  mask_at [0:127];
    logic        rd_at   [0:127];
    logic        wr_at   [0:127];
    int          resp_cyc;
    int          nrd;
    int          nwr;

    // Issue one line request; cycle 1 is the cycle after the accepting edge.
    task automatic do_line(input logic rd, input logic wr,
                           input logic [31:0] addr,
                           input logic [255:0] wd);
        @(negedge clk);
        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wd;
        resp_cyc = 0;
        nrd = 0;
        nwr = 0;
        for (int k = 1; k <= 100 && resp_cyc == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                line_address = 32'hDEAD_BEEF;
                line_wdata   = ~wd;
            end
            addr_at[k] = mem_address;
            wd_at[k]   = mem_wdata;
            mask_at[k] = mem_wmask;
            rd_at[k]   = mem_read;
            wr_at[k]   = mem_write;
            if (mem_read) nrd++;
            if (mem_write) nwr++;
            if (line_resp) begin
                resp_cyc   = k;
                line_read  = 1'b0;
                line_write = 1'b0;
            end
        end
    endtask

    // Counts deviations from the undelayed 16-cycle ISSUE/WAIT pattern.
    function automatic int seq_errs(input logic [31:0] b, input logic wr,
                                    input logic [255:0] wd);
        int e = 0;
        for (int k = 1; k <= 16; k++) begin
            int   w  = (k - 1) / 2;
            logic on = (k % 2) == 1;
            if (rd_at[k] !== (on && !wr)) e++;
            if (wr_at[k] !== (on && wr)) e++;
            if (addr_at[k] !== b + 32'(4 * w)) e++;
            if (wd_at[k] !== (wr ? wd[32*w +: 32] : 32'h0)) e++;
            if (mask_at[k] !== (wr ? 4'hF : 4'h0)) e++;
        end
        return e;
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = b + 32'(i);
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = mem[a[13:2] + 12'(i)];
        return l;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        line_read = 1'b0;
        line_write = 1'b0;
        line_address = 32'h0;
        line_wdata = '0;
        mem_resp = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({line_resp, mem_read, mem_write} !== 3'b000)
            $display("FAIL reset_strobes got=%b want=000",
                     {line_resp, mem_read, mem_write});
        else pass_cnt++;
        total++;
        if (mem_address !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0)
            $display("FAIL reset_word got=%h/%h/%h want=0",
                     mem_address, mem_wdata, mem_wmask);
        else pass_cnt++;
        total++;
        if (line_rdata !== '0)
            $display("FAIL reset_rdata got=%h want=0", line_rdata);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (mem_read !== 1'b0 || line_resp !== 1'b0)
            $display("FAIL idle_quiet got=%b%b want=00", mem_read, line_resp);
        else pass_cnt++;
    endtask

    task automatic test_read;
        do_line(1'b1, 1'b0, 32'h0000_1234, '0);
        total++;
        if (resp_cyc !== 17)
            $display("FAIL read_latency got=%0d want=17", resp_cyc);
        else pass_cnt++;
        total++;
        if (seq_errs(32'h1220, 1'b0, '0) !== 0)
            $display("FAIL read_sequence got=%0d errs want=0",
                     seq_errs(32'h1220, 1'b0, '0));
        else pass_cnt++;
        total++;
        if (line_rdata !== mk_line(32'hA000_0000))
            $display("FAIL read_data got=%h want=%h",
                     line_rdata, mk_line(32'hA000_0000));
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (line_resp !== 1'b0)
            $display("FAIL resp_pulse got=%b want=0", line_resp);
        else pass_cnt++;
    endtask

    task automatic test_write;
        logic [255:0] wd;
        wd = mk_line(32'h1111_0000);
        do_line(1'b0, 1'b1, 32'h0000_0040, wd);
        total++;
        if (seq_errs(32'h40, 1'b1, wd) !== 0 || resp_cyc !== 17)
            $display("FAIL write_sequence got=%0d errs resp=%0d want=0/17",
                     seq_errs(32'h40, 1'b1, wd), resp_cyc);
        else pass_cnt++;
        total++;
        if (line_rdata !== mk_line(32'hA000_0000))
            $display("FAIL write_keeps_rdata got=%h want=%h",
                     line_rdata, mk_line(32'hA000_0000));
        else pass_cnt++;
        do_line(1'b1, 1'b0, 32'h0000_0040, '0);
        total++;
        if (line_rdata !== wd)
            $display("FAIL write_readback got=%h want=%h", line_rdata, wd);
        else pass_cnt++;
    endtask

    task automatic test_both;
        logic [255:0] wd;
        wd = mk_line(32'h2222_0000);
        do_line(1'b1, 1'b1, 32'h0000_0080, wd);
        total++;
        if (nrd !== 0 || nwr !== 8)
            $display("FAIL both_write_wins got=rd%0d/wr%0d want=rd0/wr8",
                     nrd, nwr);
        else pass_cnt++;
        total++;
        if (mem_line(32'h80) !== wd)
            $display("FAIL both_mem got=%h want=%h", mem_line(32'h80), wd);
        else pass_cnt++;
    endtask

    task automatic test_delay;
        int e;
        delay_addr = 32'h1228;
        delay_amt = 2;
        do_line(1'b1, 1'b0, 32'h0000_1220, '0);
        delay_addr = 32'hFFFF_FFFF;
        total++;
        if (resp_cyc !== 19)
            $display("FAIL delay_latency got=%0d want=19", resp_cyc);
        else pass_cnt++;
        e = 0;
        for (int k = 6; k <= 8; k++) begin
            if (addr_at[k] !== 32'h1228) e++;
            if (rd_at[k] !== 1'b0 || wr_at[k] !== 1'b0) e++;
        end
        if (rd_at[5] !== 1'b1 || rd_at[9] !== 1'b1 || addr_at[9] !== 32'h122C) e++;
        total++;
        if (e !== 0)
            $display("FAIL delay_hold got=%0d errs want=0", e);
        else pass_cnt++;
        total++;
        if (nrd !== 8 || line_rdata !== mk_line(32'hA000_0000))
            $display("FAIL delay_data got=%0d/%h want=8/%h",
                     nrd, line_rdata, mk_line(32'hA000_0000));
        else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        int rsp;
        delay_addr = 32'h1230;
        delay_amt = 1;
        @(negedge clk);
        line_read = 1'b1;
        line_address = 32'h0000_1220;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        line_read = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({line_resp, mem_read, mem_write, mem_wmask} !== 7'h0 ||
            mem_address !== 32'h0 || mem_wdata !== 32'h0 || line_rdata !== '0)
            $display("FAIL midrst_outputs got=%b%b%b %h %h want=0",
                     line_resp, mem_read, mem_write, mem_address, line_rdata);
        else pass_cnt++;
        total++;
        if (mem_resp !== 1'b1)
            $display("FAIL midrst_stray got=%b want=1", mem_resp);
        else pass_cnt++;
        rst = 1'b0;
        delay_addr = 32'hFFFF_FFFF;
        rsp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (line_resp || mem_read || mem_write) rsp++;
        end
        total++;
        if (rsp !== 0)
            $display("FAIL midrst_quiet got=%0d want=0", rsp);
        else pass_cnt++;
        do_line(1'b1, 1'b0, 32'h0000_1220, '0);
        total++;
        if (resp_cyc !== 17 || line_rdata !== mk_line(32'hA000_0000))
            $display("FAIL midrst_reread got=%0d/%h want=17/%h",
                     resp_cyc, line_rdata, mk_line(32'hA000_0000));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [255:0] wd;
        wd = mk_line(32'h3333_0000);
        do_line(1'b1, 1'b0, 32'h0000_0040, '0);
        do_line(1'b0, 1'b1, 32'h0000_031C, wd);
        total++;
        if (seq_errs(32'h300, 1'b1, wd) !== 0 || resp_cyc !== 17)
            $display("FAIL b2b_sequence got=%0d errs resp=%0d want=0/17",
                     seq_errs(32'h300, 1'b1, wd), resp_cyc);
        else pass_cnt++;
        total++;
        if (mem_line(32'h300) !== wd)
            $display("FAIL b2b_mem got=%h want=%h", mem_line(32'h300), wd);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem[12'h488 + 12'(i)] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_read();
        test_write();
        test_both();
        test_delay();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/cacheline_word_adapter.md
Name: cacheline_word_adapter

Overview:
Sits directly upstream of port B of the dual-port magic memory (data side). Accepts whole-cacheline read/write requests from the data cache or arbiter. Serialises each request into LINE_WORDS single-word accesses on the 32-bit memory port. Returns the assembled line with a one-cycle response.

Parameters:
LINE_WORDS, 8, number of 32-bit words per cacheline; must be a power of two ≥2.
OFFSET_BITS, log2(LINE_WORDS*4) = 5, line byte-offset width (derived, not overridden).

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  reset, synchronous, active-high
line_read  input  1  line read request; held until line_resp
line_write  input  1  line write request; held until line_resp
line_address  input  32  byte address; low OFFSET_BITS ignored
line_wdata  input  32*LINE_WORDS  write line; word i at bits [32i+31:32i]
line_rdata  output  32*LINE_WORDS  assembled read line, same packing
line_resp  output  1  one-cycle completion pulse
mem_read  output  1  word read strobe to memory port B
mem_write  output  1  word write strobe to memory port B
mem_wmask  output  4  byte mask to memory
mem_address  output  32  word byte address to memory
mem_wdata  output  32  word write data
mem_resp  input  1  memory word response
mem_rdata  input  32  memory word read data

Behaviour:
- Reset: all outputs 0; line_rdata cleared to 0; word counter 0; FSM to IDLE. Reset mid-transaction aborts the transaction with no line_resp. A mem_resp arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If line_write or line_read is high at the clock edge, latch the following, clear the counter, and go to ISSUE:
    - base = {line_address[31:OFFSET_BITS], OFFSET_BITS'b0}
    - line_wdata
    - op, where write wins if both requests are high
  - Otherwise stay. mem_resp is ignored in IDLE.
- ISSUE: lasts exactly one cycle.
  - mem_read = op==read; mem_write = op==write.
  - mem_address = base + 4*counter.
  - mem_wmask = 4'hF on write, 4'h0 on read.
  - mem_wdata = latched word[counter] on write, 0 on read.
  - Next state WAIT.
- WAIT: strobes deasserted; mem_address, mem_wdata and mem_wmask are held.
  - The strobe drop is mandatory: the memory re-samples a held strobe every cycle and would return stale data.
  - On mem_resp=1:
    - For a read, capture mem_rdata into line_rdata word[counter].
    - If counter==LINE_WORDS-1, go to DONE; else increment counter and go to ISSUE.
  - On mem_resp=0, stay with no reissue. There is no timeout.
- DONE: line_resp=1 for exactly one cycle, then IDLE.
  - line_rdata is valid in DONE and holds until the next read capture or reset.
  - Write transactions leave line_rdata unchanged.
- Latency with 1-cycle memory:
  - Request sampled at edge E0 gives ISSUE/WAIT pairs in cycles 1..16 and line_resp in cycle 17.
  - Each extra memory wait cycle adds exactly one.
- Input changes after acceptance (address, data, request deassert) have no effect until IDLE.
- A request still high in the cycle after DONE starts a new transaction. Requesters must drop their request on line_resp.
- Address arithmetic is 32-bit. A base near 0xFFFF_FFE0 does not wrap within a line, because the base is aligned.
- The counter is log2(LINE_WORDS) bits wide. It never wraps inside a transaction.

Test Plan:
1. Line read from 0x0000_1234, memory word at 0x1220+4i preloaded with 0xA000_0000+i.
   - mem_address sequence is 0x1220, 0x1224, …, 0x123C.
   - Each mem_read is a 1-cycle pulse followed by a 1-cycle gap.
   - line_resp is high only in cycle 17.
   - line_rdata word i = 0xA000_0000+i.
2. Line write to 0x40 with word i = 0x1111_0000+i.
   - 8 mem_write pulses with wmask 4'hF and addresses 0x40..0x5C.
   - A following line read of 0x40 returns the same words.
3. line_read and line_write both high, address 0x80.
   - Only mem_write pulses occur; mem_read stays 0 for the whole transaction.
4. Memory model delays mem_resp 3 cycles on word 2.
   - FSM holds in WAIT with no extra strobe.
   - mem_address is held at base+8.
   - line_resp arrives in cycle 19.
5. rst asserted during WAIT of word 4, and the memory asserts mem_resp the next cycle.
   - All outputs are 0 the cycle after rst.
   - No line_resp occurs and the stray resp is ignored.
   - A subsequent read of 0x1220 returns correct data in cycle 17.
6. Read completes, then the requester issues a write at the cycle after line_resp.
   - The write starts cleanly with counter 0.
   - Address sequence restarts at the new base, with no overlap or skipped word.
